// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory controller and its per-core fetch requesters.
package imem_pkg;

    localparam int unsigned IMEM_ADDR_W = 16;
    localparam int unsigned IMEM_DATA_W = 8;
    localparam int unsigned FETCH_ST_W  = 3;

    typedef logic [FETCH_ST_W-1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE  = FETCH_ST_W'(0);
    localparam fetch_state_t ST_REQ   = FETCH_ST_W'(1);
    localparam fetch_state_t ST_DATA  = FETCH_ST_W'(2);
    localparam fetch_state_t ST_HOLD  = FETCH_ST_W'(3);
    localparam fetch_state_t ST_FLUSH = FETCH_ST_W'(4);
    localparam fetch_state_t ST_ERR   = FETCH_ST_W'(5);

    // Read-side request payload a requester presents to the controller
    typedef struct packed {
        logic                   rden;
        logic [IMEM_ADDR_W-1:0] addr;
    } imem_rd_req_t;

    function automatic logic [IMEM_ADDR_W-1:0] pc_next(input logic [IMEM_ADDR_W-1:0] pc);
        return pc + IMEM_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/imem_fetch_requester.sv
// Per-core instruction fetch initiator: requests a byte at pc from the shared imem controller,
// waits for the grant, captures the returned byte and presents it to decode with valid/stall.
module imem_fetch_requester
    import imem_pkg::*;
#(
    parameter int unsigned            CORE_ID  = 0,
    parameter logic [IMEM_ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned            TIMEOUT  = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   jump,
    input  logic [IMEM_ADDR_W-1:0] jump_addr,
    input  logic                   acq,
    input  logic [IMEM_DATA_W-1:0] Dq,
    output logic                   rden,
    output logic                   wren,
    output logic [IMEM_ADDR_W-1:0] Address,
    output logic [15:0]            Din,
    output logic [IMEM_DATA_W-1:0] instr,
    output logic                   instr_valid,
    output logic [IMEM_ADDR_W-1:0] pc,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    if (CORE_ID > 31 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_chk
        $error("imem_fetch_requester: CORE_ID or TIMEOUT out of range");
    end

    fetch_state_t           state_q, state_d;
    imem_rd_req_t           req_q, req_d;
    logic [IMEM_ADDR_W-1:0] pc_q, pc_d;
    logic [IMEM_DATA_W-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   next_fetch;

    assign next_fetch = start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Jump outranks grant and stall everywhere except ERR
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (jump || start) state_d = next_fetch ? ST_REQ : ST_IDLE;
            ST_REQ: begin
                if (jump)                 state_d = ST_FLUSH;
                else if (acq)             state_d = ST_DATA;
                else if (cnt_q == TO_LAST) state_d = ST_ERR;
            end
            ST_DATA: begin
                if (jump)       state_d = ST_FLUSH;
                else if (stall) state_d = ST_HOLD;
                else            state_d = next_fetch ? ST_REQ : ST_IDLE;
            end
            ST_HOLD:  if (jump || !stall) state_d = next_fetch ? ST_REQ : ST_IDLE;
            ST_FLUSH: state_d = next_fetch ? ST_REQ : ST_IDLE;
            ST_ERR:   state_d = ST_ERR;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        cnt_d   = '0;
        instr_d = instr_q;
        valid_d = valid_q & stall;
        err_d   = err_q;
        unique case (state_q)
            ST_REQ: if (!jump && !acq) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == TO_LAST) err_d = 1'b1;
            end
            ST_DATA: if (!jump) begin
                instr_d = Dq;
                valid_d = 1'b1;
                if (!stall) pc_d = pc_next(pc_q);
            end
            ST_HOLD: if (!jump && !stall) pc_d = pc_next(pc_q);
            default: ;
        endcase
        if (jump && state_q != ST_ERR) begin
            pc_d    = jump_addr;
            valid_d = 1'b0;
        end
        // Address tracks the pc of the request about to be raised, and is held otherwise
        req_d.rden = (state_d == ST_REQ);
        req_d.addr = (state_d == ST_REQ) ? pc_d : req_q.addr;
        busy_d     = (state_d == ST_REQ) || (state_d == ST_DATA) || (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            req_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rden        = req_q.rden;
    assign Address     = req_q.addr;
    assign wren        = 1'b0;
    assign Din         = '0;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_imem_fetch_requester.sv
// Directed bench for imem_fetch_requester with a one-cycle-grant memory responder and a byte scoreboard.
module tb_imem_fetch_requester;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stall, jump, acq;
    logic [15:0] jump_addr;
    logic [7:0]  Dq;
    logic        rden, wren, instr_valid, busy, timeout_err;
    logic [15:0] Address, Din, pc;
    logic [7:0]  instr;

    logic        w_start, w_acq;
    logic [7:0]  w_Dq;
    logic        w_rden, w_wren, w_valid, w_busy, w_err;
    logic [15:0] w_Address, w_Din, w_pc;
    logic [7:0]  w_instr;

    logic [7:0]  mem [256];
    logic [7:0]  sb_q [$];
    logic        grant_en;
    logic        rsp_pend;
    logic [7:0]  rsp_addr;
    int          n_cmp = 0;
    int          n_err = 0;
    int          lat;

    always #5 clk = ~clk;

    imem_fetch_requester #(.CORE_ID(0), .RESET_PC(16'h0000), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .jump(jump), .jump_addr(jump_addr),
        .acq(acq), .Dq(Dq), .rden(rden), .wren(wren), .Address(Address), .Din(Din),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .busy(busy), .timeout_err(timeout_err)
    );

    imem_fetch_requester #(.CORE_ID(1), .RESET_PC(16'hFFFF), .TIMEOUT(15)) dut_wrap (
        .clk(clk), .rst(rst), .start(w_start), .stall(1'b0), .jump(1'b0), .jump_addr(16'h0000),
        .acq(w_acq), .Dq(w_Dq), .rden(w_rden), .wren(w_wren), .Address(w_Address), .Din(w_Din),
        .instr(w_instr), .instr_valid(w_valid), .pc(w_pc), .busy(w_busy), .timeout_err(w_err)
    );

    // Controller model: grant one cycle, return the byte on the following cycle
    always @(negedge clk) begin
        if (rst) begin
            acq      = 1'b0;
            rsp_pend = 1'b0;
        end else begin
            acq = 1'b0;
            if (rsp_pend) begin
                Dq       = mem[rsp_addr];
                rsp_pend = 1'b0;
            end else if (grant_en && rden) begin
                acq      = 1'b1;
                rsp_addr = Address[7:0];
                rsp_pend = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] obs);
        logic [31:0] e;
        e = 32'hFFFF_FFFF;
        if (sb_q.size() > 0) e = 32'(sb_q.pop_front());
        chk(tag, 32'(obs), e);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 8);
    endtask

    task automatic fetch_one(input logic [15:0] a);
        start = 1'b1;
        sb_q.push_back(mem[a[7:0]]);
        step();
        chk("f_rden", 32'(rden), 1);
        chk("f_addr", 32'(Address), 32'(a));
        start = 1'b0;
        wait_valid(lat);
        chk("f_lat", 32'(lat), 2);
        pop_chk("f_instr", instr);
        chk("f_pc", 32'(pc), 32'(a + 16'd1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        rst = 1'b1; start = 1'b0; stall = 1'b0; jump = 1'b0; jump_addr = '0;
        Dq = '0; grant_en = 1'b1; rsp_pend = 1'b0; acq = 1'b0; rsp_addr = '0;
        w_start = 1'b0; w_acq = 1'b0; w_Dq = '0;
        step(); step();

        // Reset state
        chk("rst_rden", 32'(rden), 0);
        chk("rst_addr", 32'(Address), 0);
        chk("rst_instr", 32'(instr), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(timeout_err), 0);
        chk("rst_wpc", 32'(w_pc), 32'hFFFF);
        chk("rst_wren_din", {15'd0, wren, Din}, 0);
        rst = 1'b0;

        // Basic fetch from address 0
        fetch_one(16'h0000);
        step();
        chk("b_busy", 32'(busy), 0);
        chk("b_valid_clr", 32'(instr_valid), 0);

        // Stall on arrival: HOLD presents the byte until stall drops
        stall = 1'b1; start = 1'b1;
        sb_q.push_back(mem[1]);
        step();
        chk("s_addr", 32'(Address), 1);
        start = 1'b0;
        wait_valid(lat);
        chk("s_lat", 32'(lat), 2);
        pop_chk("s_instr", instr);
        chk("s_busy", 32'(busy), 0);
        for (int k = 0; k < 4; k++) begin
            chk("s_hold_valid", 32'(instr_valid), 1);
            chk("s_hold_instr", 32'(instr), 32'h3C);
            chk("s_hold_pc", 32'(pc), 1);
            if (k < 3) step();
        end
        stall = 1'b0; start = 1'b1;
        step();
        chk("s_pc_inc", 32'(pc), 2);
        chk("s_next_rden", 32'(rden), 1);
        chk("s_next_addr", 32'(Address), 2);
        chk("s_valid_clr", 32'(instr_valid), 0);
        sb_q.push_back(mem[2]);
        start = 1'b0;
        wait_valid(lat);
        pop_chk("s2_instr", instr);
        chk("s2_pc", 32'(pc), 3);
        step();

        // Jump while in DATA: the in-flight byte is dropped
        start = 1'b1;
        step();
        chk("j_rden", 32'(rden), 1);
        step();
        jump = 1'b1; jump_addr = 16'h0040;
        step();
        jump = 1'b0;
        chk("j_flush_rden", 32'(rden), 0);
        chk("j_flush_valid", 32'(instr_valid), 0);
        chk("j_flush_pc", 32'(pc), 32'h40);
        chk("j_flush_busy", 32'(busy), 1);
        step();
        chk("j_req_rden", 32'(rden), 1);
        chk("j_req_addr", 32'(Address), 32'h40);
        chk("j_req_valid", 32'(instr_valid), 0);
        start = 1'b0;
        sb_q.push_back(mem[8'h40]);
        wait_valid(lat);
        chk("j_lat", 32'(lat), 2);
        pop_chk("j_instr", instr);
        chk("j_pc", 32'(pc), 32'h41);
        step();

        // Jump coincident with acq in REQ: grant ignored
        start = 1'b1;
        step();
        chk("ja_rden", 32'(rden), 1);
        jump = 1'b1; jump_addr = 16'h0080;
        step();
        jump = 1'b0;
        chk("ja_flush_rden", 32'(rden), 0);
        chk("ja_flush_pc", 32'(pc), 32'h80);
        chk("ja_flush_valid", 32'(instr_valid), 0);
        step();
        chk("ja_req_addr", 32'(Address), 32'h80);
        start = 1'b0;
        sb_q.push_back(mem[8'h80]);
        wait_valid(lat);
        pop_chk("ja_instr", instr);
        chk("ja_pc", 32'(pc), 32'h81);
        step();

        // Timeout: 15 REQ cycles without acq
        grant_en = 1'b0; start = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk("t_rden_last", 32'(rden), 1);
        chk("t_err_pre", 32'(timeout_err), 0);
        step();
        chk("t_err", 32'(timeout_err), 1);
        chk("t_rden", 32'(rden), 0);
        chk("t_busy", 32'(busy), 0);
        grant_en = 1'b1; jump = 1'b1; jump_addr = 16'h0010;
        step();
        jump = 1'b0;
        step(); step();
        chk("t_sticky_err", 32'(timeout_err), 1);
        chk("t_sticky_rden", 32'(rden), 0);
        chk("t_sticky_pc", 32'(pc), 32'h81);
        start = 1'b0;

        // Async reset mid-request with a byte still presented
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("r_err_clr", 32'(timeout_err), 0);
        start = 1'b1;
        sb_q.push_back(mem[0]);
        step();
        step();
        grant_en = 1'b0;
        step();
        pop_chk("r_instr", instr);
        chk("r_pre_valid", 32'(instr_valid), 1);
        chk("r_pre_rden", 32'(rden), 1);
        stall = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("r_async_rden", 32'(rden), 0);
        chk("r_async_pc", 32'(pc), 0);
        chk("r_async_valid", 32'(instr_valid), 0);
        chk("r_async_busy", 32'(busy), 0);
        rst = 1'b0; start = 1'b0; stall = 1'b0; grant_en = 1'b1;
        step();
        fetch_one(16'h0000);
        step();

        // PC wrap on the RESET_PC=FFFF instance
        w_start = 1'b1;
        step();
        chk("w_rden", 32'(w_rden), 1);
        chk("w_addr", 32'(w_Address), 32'hFFFF);
        w_acq = 1'b1; w_start = 1'b0;
        step();
        w_acq = 1'b0; w_Dq = mem[8'hFF];
        sb_q.push_back(mem[8'hFF]);
        step();
        chk("w_valid", 32'(w_valid), 1);
        pop_chk("w_instr", w_instr);
        chk("w_pc_wrap", 32'(w_pc), 0);
        w_start = 1'b1;
        step();
        chk("w_next_rden", 32'(w_rden), 1);
        chk("w_next_addr", 32'(w_Address), 0);
        w_start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
